// File: rtl/ladner_fischer_pipe_adder.sv
// ============================================================================
//  Module   : ladner_fischer_pipe_adder
//  Purpose  : Pipelined Ladner-Fischer prefix adder/subtractor, valid/ready.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ladner_fischer_pipe_adder #(
  parameter int WIDTH     = 16,
  parameter int REG_EVERY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LOG2W = $clog2(WIDTH);

  // A stalled output freezes the whole pipe; bubbles are carried, not collapsed.
  logic w_en;
  assign w_en     = ~(out_valid & ~out_ready);
  assign in_ready = w_en;

  logic [WIDTH-1:0] w_bb;
  logic             w_c0;
  assign w_bb = sub ? ~b : b;
  assign w_c0 = sub | cin;

  logic [WIDTH-1:0] r_g0, r_p0;
  logic             r_c0, r_v0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_g0 <= '0;
      r_p0 <= '0;
      r_c0 <= 1'b0;
    end else if (w_en) begin
      r_v0 <= in_valid;
      r_g0 <= a & w_bb;
      r_p0 <= a ^ w_bb;
      r_c0 <= w_c0;
    end
  end

  // Per-level group generate/propagate, the per-bit propagate kept for the sum, c0 and valid.
  logic [WIDTH-1:0] w_lvl_g  [LOG2W+1];
  logic [WIDTH-1:0] w_lvl_p  [LOG2W+1];
  logic [WIDTH-1:0] w_lvl_pb [LOG2W+1];
  logic [LOG2W:0]   w_lvl_c0;
  logic [LOG2W:0]   w_lvl_v;

  assign w_lvl_g[0]  = r_g0;
  assign w_lvl_p[0]  = r_p0;
  assign w_lvl_pb[0] = r_p0;
  assign w_lvl_c0[0] = r_c0;
  assign w_lvl_v[0]  = r_v0;

  for (genvar k = 1; k <= LOG2W; k++) begin : g_lvl
    logic [WIDTH-1:0] w_g, w_p;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (((i >> (k - 1)) % 2) == 1) begin : g_op
        // Combine with the top bit of the adjacent lower 2^(k-1) block.
        localparam int J = ((i >> (k - 1)) << (k - 1)) - 1;
        assign w_g[i] = w_lvl_g[k-1][i] | (w_lvl_p[k-1][i] & w_lvl_g[k-1][J]);
        assign w_p[i] = w_lvl_p[k-1][i] & w_lvl_p[k-1][J];
      end else begin : g_pass
        assign w_g[i] = w_lvl_g[k-1][i];
        assign w_p[i] = w_lvl_p[k-1][i];
      end
    end

    if ((k % REG_EVERY == 0) || (k == LOG2W)) begin : g_reg
      logic [WIDTH-1:0] r_g, r_p, r_pb;
      logic             r_c0, r_v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v  <= 1'b0;
          r_g  <= '0;
          r_p  <= '0;
          r_pb <= '0;
          r_c0 <= 1'b0;
        end else if (w_en) begin
          r_v  <= w_lvl_v[k-1];
          r_g  <= w_g;
          r_p  <= w_p;
          r_pb <= w_lvl_pb[k-1];
          r_c0 <= w_lvl_c0[k-1];
        end
      end

      assign w_lvl_g[k]  = r_g;
      assign w_lvl_p[k]  = r_p;
      assign w_lvl_pb[k] = r_pb;
      assign w_lvl_c0[k] = r_c0;
      assign w_lvl_v[k]  = r_v;
    end else begin : g_comb
      assign w_lvl_g[k]  = w_g;
      assign w_lvl_p[k]  = w_p;
      assign w_lvl_pb[k] = w_lvl_pb[k-1];
      assign w_lvl_c0[k] = w_lvl_c0[k-1];
      assign w_lvl_v[k]  = w_lvl_v[k-1];
    end
  end

  // Carry into bit i+1 is the full prefix G[i:0] plus the incoming carry through P[i:0].
  logic [WIDTH:0] w_c;
  assign w_c = {w_lvl_g[LOG2W] | (w_lvl_p[LOG2W] & {WIDTH{w_lvl_c0[LOG2W]}}), w_lvl_c0[LOG2W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (w_en) begin
      out_valid <= w_lvl_v[LOG2W];
      sum       <= w_lvl_pb[LOG2W] ^ w_c[WIDTH-1:0];
      cout      <= w_c[WIDTH];
      ovf       <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

endmodule

`default_nettype wire
